// File: rtl/sync_reset_pkg.sv
`timescale 1ns/100ps
// sync_reset_pkg
// Shared types and default constants for the reset generator.
//   state_t              : FSM encoding (RESET, HOLD, RUN, SOFT)
//   DEF_SYNC_STAGES      : default deassertion synchronizer depth
//   DEF_HOLD_CYCLES      : default sync_reset stretch length in cycles
package sync_reset_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_SOFT  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/reset_sync.sv
`timescale 1ns/100ps
// reset_sync
// Asynchronous-assert / synchronous-deassert reset synchronizer.
// All stages clear immediately when async_reset_n goes low; after release
// a 1 ripples through the chain, so rst_sync rises SYNC_STAGES edges later.
// Ports:
//   clk           in  : clock
//   async_reset_n in  : asynchronous active-low reset
//   rst_sync      out : synchronized release (1 = out of reset)
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic async_reset_n,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_reset_gen.sv
`timescale 1ns/100ps
// sync_reset_gen
// Produces the active-high synchronous reset for downstream flops. The board
// reset is synchronized on release and stretched to HOLD_CYCLES cycles; a
// soft_req in RUN re-asserts sync_reset for HOLD_CYCLES cycles.
// Ports:
//   clk           in  : clock
//   async_reset_n in  : asynchronous active-low board reset
//   soft_req      in  : level soft-reset request (sampled only in RUN)
//   soft_ack      out : one-cycle pulse on the first RUN cycle after SOFT
//   sync_reset    out : registered active-high reset to downstream logic
//   ready         out : high only in RUN
//   dbg_state     out : current FSM state, for observation only
//
// Handshake: the requester raises soft_req and holds it; the request is
// taken at a RUN edge. soft_ack is high for exactly one cycle when the soft
// reset completes; the requester must drop soft_req in that cycle, otherwise
// the next edge (still RUN) accepts it as a fresh request. An async reset
// during HOLD/SOFT aborts without any soft_ack.
module sync_reset_gen
  import sync_reset_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic   clk,
  input  logic   async_reset_n,
  input  logic   soft_req,
  output logic   soft_ack,
  output logic   sync_reset,
  output logic   ready,
  output state_t dbg_state
);

  localparam int              CW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(HOLD_CYCLES - 1);

  logic          rst_sync;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_reset_q, sync_reset_d;
  logic          ready_q, ready_d;
  logic          soft_ack_q, soft_ack_d;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .rst_sync      (rst_sync)
  );

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      sync_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      soft_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_reset_q <= sync_reset_d;
      ready_q      <= ready_d;
      soft_ack_q   <= soft_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET: begin
        cnt_d = '0;
        if (rst_sync) state_d = ST_HOLD;
      end
      ST_HOLD, ST_SOFT: begin
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          // saturating: the counter never wraps
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (soft_req) state_d = ST_SOFT;
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
    // Outputs are computed from the next state so that the registered
    // copies line up with the state register.
    sync_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    soft_ack_d   = (state_q == ST_SOFT) && (state_d == ST_RUN);
  end

  assign sync_reset = sync_reset_q;
  assign ready      = ready_q;
  assign soft_ack   = soft_ack_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sync_reset_gen.sv
`timescale 1ns/100ps
module tb_sync_reset_gen;
  import sync_reset_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk           = 1'b0;
  logic   async_reset_n = 1'b1;
  logic   soft_req      = 1'b0;
  logic   soft_ack;
  logic   sync_reset;
  logic   ready;
  state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  sync_reset_gen dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .soft_req      (soft_req),
    .soft_ack      (soft_ack),
    .sync_reset    (sync_reset),
    .ready         (ready),
    .dbg_state     (dbg_state)
  );

  // Downstream synchronous-reset flop fed by sync_reset; d toggles every 23 ns
  // on a 0.3 ns offset so it never coincides with a sampling point.
  logic dff_d = 1'b0;
  logic dff_q;
  always @(posedge clk) dff_q <= sync_reset ? 1'b0 : dff_d;
  initial begin
    #0.3;
    forever #23 dff_d = ~dff_d;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 async_reset_n = 1'b0;
    #1;
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL por_sync_reset got %b exp 1", sync_reset); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL por_ready got %b exp 0", ready); end
    checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL por_soft_ack got %b exp 0", soft_ack); end
    checks++; if (dbg_state !== ST_RESET) begin failures++; $display("FAIL por_state got %0d exp %0d", dbg_state, ST_RESET); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    async_reset_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      checks++; if (sync_reset !== (e < 19)) begin failures++; $display("FAIL rel_sync_reset edge %0d got %b exp %b", e, sync_reset, (e < 19)); end
      checks++; if (ready !== (e >= 19)) begin failures++; $display("FAIL rel_ready edge %0d got %b exp %b", e, ready, (e >= 19)); end
      checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL rel_soft_ack edge %0d got %b exp 0", e, soft_ack); end
      if (e == 3) begin
        checks++; if (dbg_state !== ST_HOLD) begin failures++; $display("FAIL rel_state_hold got %0d exp %0d", dbg_state, ST_HOLD); end
      end
    end
  endtask

  task automatic test_soft_reset();
    @(negedge clk);
    soft_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL soft_start_sync_reset got %b exp 1", sync_reset); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL soft_start_ready got %b exp 0", ready); end
    checks++; if (dbg_state !== ST_SOFT) begin failures++; $display("FAIL soft_start_state got %0d exp %0d", dbg_state, ST_SOFT); end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      checks++; if (sync_reset !== (k < 16)) begin failures++; $display("FAIL soft_sync_reset t+%0d got %b exp %b", k, sync_reset, (k < 16)); end
      checks++; if (ready !== (k == 16)) begin failures++; $display("FAIL soft_ready t+%0d got %b exp %b", k, ready, (k == 16)); end
      checks++; if (soft_ack !== (k == 16)) begin failures++; $display("FAIL soft_ack t+%0d got %b exp %b", k, soft_ack, (k == 16)); end
    end
    soft_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL soft_ack_single got %b exp 0", soft_ack); end
    checks++; if (sync_reset !== 1'b0) begin failures++; $display("FAIL soft_after_sync_reset got %b exp 0", sync_reset); end
    checks++; if (dbg_state !== ST_RUN) begin failures++; $display("FAIL soft_after_state got %0d exp %0d", dbg_state, ST_RUN); end
  endtask

  task automatic test_abort();
    @(negedge clk);
    soft_req = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    async_reset_n = 1'b0;
    soft_req      = 1'b0;
    #1;
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL abort_sync_reset got %b exp 1", sync_reset); end
    checks++; if (dbg_state !== ST_RESET) begin failures++; $display("FAIL abort_state got %0d exp %0d", dbg_state, ST_RESET); end
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk); #1;
      checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL abort_hold_ack edge %0d got %b exp 0", e, soft_ack); end
      checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL abort_hold_sync_reset edge %0d got %b exp 1", e, sync_reset); end
    end
    @(negedge clk);
    async_reset_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      checks++; if (sync_reset !== (e < 19)) begin failures++; $display("FAIL abort_rel_sync_reset edge %0d got %b exp %b", e, sync_reset, (e < 19)); end
      checks++; if (ready !== (e >= 19)) begin failures++; $display("FAIL abort_rel_ready edge %0d got %b exp %b", e, ready, (e >= 19)); end
      checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL abort_rel_ack edge %0d got %b exp 0", e, soft_ack); end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    #3 async_reset_n = 1'b0;
    #1;
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL glitch_sync_reset got %b exp 1", sync_reset); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL glitch_ready got %b exp 0", ready); end
    checks++; if (dbg_state !== ST_RESET) begin failures++; $display("FAIL glitch_state got %0d exp %0d", dbg_state, ST_RESET); end
    #1 async_reset_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      checks++; if (sync_reset !== (e < 19)) begin failures++; $display("FAIL glitch_rel_sync_reset edge %0d got %b exp %b", e, sync_reset, (e < 19)); end
      checks++; if (ready !== (e >= 19)) begin failures++; $display("FAIL glitch_rel_ready edge %0d got %b exp %b", e, ready, (e >= 19)); end
    end
  endtask

  task automatic test_req_during_hold();
    @(negedge clk);
    async_reset_n = 1'b0;
    soft_req      = 1'b1;
    @(negedge clk);
    async_reset_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk); #1;
      checks++; if (sync_reset !== (e < 19)) begin failures++; $display("FAIL hreq_sync_reset edge %0d got %b exp %b", e, sync_reset, (e < 19)); end
      checks++; if (ready !== (e >= 19)) begin failures++; $display("FAIL hreq_ready edge %0d got %b exp %b", e, ready, (e >= 19)); end
    end
    // first RUN edge accepts the held request
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_SOFT) begin failures++; $display("FAIL hreq_enter_soft got %0d exp %0d", dbg_state, ST_SOFT); end
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL hreq_enter_sync_reset got %b exp 1", sync_reset); end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      checks++; if (soft_ack !== (k == 16)) begin failures++; $display("FAIL hreq_ack1 t+%0d got %b exp %b", k, soft_ack, (k == 16)); end
      checks++; if (sync_reset !== (k < 16)) begin failures++; $display("FAIL hreq_sr1 t+%0d got %b exp %b", k, sync_reset, (k < 16)); end
    end
    // soft_req left high past the ack: a second soft reset starts
    @(posedge clk); #1;
    checks++; if (dbg_state !== ST_SOFT) begin failures++; $display("FAIL hreq_second_state got %0d exp %0d", dbg_state, ST_SOFT); end
    checks++; if (sync_reset !== 1'b1) begin failures++; $display("FAIL hreq_second_sync_reset got %b exp 1", sync_reset); end
    checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL hreq_second_ack got %b exp 0", soft_ack); end
    soft_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      checks++; if (soft_ack !== (k == 16)) begin failures++; $display("FAIL hreq_ack2 t+%0d got %b exp %b", k, soft_ack, (k == 16)); end
      checks++; if (ready !== (k == 16)) begin failures++; $display("FAIL hreq_ready2 t+%0d got %b exp %b", k, ready, (k == 16)); end
    end
    @(posedge clk); #1;
    checks++; if (soft_ack !== 1'b0) begin failures++; $display("FAIL hreq_ack2_single got %b exp 0", soft_ack); end
  endtask

  task automatic test_integration();
    logic pre_sr;
    logic pre_d;
    logic exp_q;
    int   sr_edges;
    sr_edges = 0;
    soft_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #18.5;
      pre_sr = sync_reset;
      pre_d  = dff_d;
      if (pre_sr) sr_edges++;
      @(posedge clk); #1;
      exp_q = pre_sr ? 1'b0 : pre_d;
      checks++; if (dff_q !== exp_q) begin failures++; $display("FAIL integ_q edge %0d got %b exp %b", i, dff_q, exp_q); end
      if (soft_ack) soft_req = 1'b0;
    end
    checks++; if (sr_edges !== 16) begin failures++; $display("FAIL integ_reset_edges got %0d exp 16", sr_edges); end
  endtask

  initial begin
    test_reset();
    test_soft_reset();
    test_abort();
    test_glitch();
    test_req_during_hold();
    test_integration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_reset_gen.md
# sync_reset_gen

Reset generator that sits directly upstream of the synchronous-reset flops (dff_syncres and its siblings) and produces their active-high `sync_reset`. It takes the board-level asynchronous active-low reset, synchronizes its deassertion to `clk`, and stretches it to a guaranteed minimum width. It also services a soft-reset request/acknowledge handshake, so logic can re-reset the downstream pipeline without touching the board reset.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: depth of the deassertion synchronizer. Legal range ≥ 2.
- `HOLD_CYCLES`, default 16: number of cycles `sync_reset` is held after synchronized release, and for every soft reset. Legal range ≥ 1.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `async_reset_n`  input  1  asynchronous, active-low reset. Assertion acts immediately; deassertion is synchronized internally.
- `soft_req`  input  1  level request for a soft reset. Sampled only in RUN.
- `soft_ack`  output  1  one-cycle pulse when a soft reset completes.
- `sync_reset`  output  1  active-high synchronous reset to downstream flops. Registered.
- `ready`  output  1  high only in RUN.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops, all cleared asynchronously by `async_reset_n` low, shifting in 1. The last stage is `rst_sync`.
- Counter: width `$clog2(HOLD_CYCLES+1)`, counts up from 0 and never wraps.
- Reset values, applied asynchronously while `async_reset_n` = 0:
  - state = RESET, counter = 0
  - `sync_reset` = 1, `ready` = 0, `soft_ack` = 0
- States:
  - RESET: stays while `rst_sync` = 0. When `rst_sync` = 1, moves to HOLD with counter = 0.
  - HOLD: `sync_reset` = 1. Counter increments each cycle. When counter == `HOLD_CYCLES`-1, moves to RUN.
  - RUN: `sync_reset` = 0, `ready` = 1. If `soft_req` = 1, moves to SOFT with counter = 0.
  - SOFT: `sync_reset` = 1, `ready` = 0. Counter increments. When counter == `HOLD_CYCLES`-1, moves to RUN and asserts `soft_ack` for that first RUN cycle.
- `soft_req` is ignored in RESET, HOLD and SOFT; requests are not queued. A request still held on entry to RUN is accepted at the first RUN edge.
- Requester handshake: the requester must drop `soft_req` in the cycle `soft_ack` is high. If `soft_req` is still high at the following edge, a new soft reset starts.
- Reset mid-operation: `async_reset_n` low in HOLD or SOFT aborts immediately. No `soft_ack` is produced, and an in-flight request is lost.
- A glitch on `async_reset_n` shorter than one clock period still forces the full RESET→HOLD→RUN sequence.

## Timing
- `sync_reset` assertion on `async_reset_n` falling is combinational-async, with no clock needed.
- Release sequence, with `async_reset_n` rising before edge 1:
  - `rst_sync` = 1 after edge `SYNC_STAGES`.
  - HOLD is entered at edge `SYNC_STAGES`+1.
  - `sync_reset` falls and `ready` rises at edge `SYNC_STAGES`+`HOLD_CYCLES`+1. With default parameters that is edge 19.
- Soft reset: `soft_req` sampled at edge t in RUN.
  - `sync_reset` = 1 and `ready` = 0 from edge t.
  - `sync_reset` falls at edge t+`HOLD_CYCLES`, so it is high for exactly `HOLD_CYCLES` cycles.
  - `soft_ack` = 1 from edge t+`HOLD_CYCLES` to edge t+`HOLD_CYCLES`+1.
- `HOLD_CYCLES` = 1: HOLD and SOFT each last exactly one cycle.
- All outputs are registered; no combinational input-to-output path exists except the asynchronous reset.

## Structure
- Shared package `sync_reset_pkg`:
  - state enum typedef: RESET, HOLD, RUN, SOFT
  - default constants for `SYNC_STAGES` and `HOLD_CYCLES`
- Sub-module `reset_sync`: the synchronizer chain.
  - Ports: `clk`, `async_reset_n`, `rst_sync`; parameter `SYNC_STAGES`.
  - Reusable elsewhere in the design.
- Top level holds the FSM, the counter and the output registers.

## Test plan
Clock period is 20 ns; default parameters.
1. Power-on: hold `async_reset_n` low for 3 cycles, then release → `sync_reset` = 1 and `ready` = 0 through edge 18; `sync_reset` = 0 and `ready` = 1 from edge 19.
2. Soft reset: in RUN, raise `soft_req` at edge t and drop it on ack → `sync_reset` high for exactly 16 cycles; single `soft_ack` pulse at edge t+16.
3. Abort: pull `async_reset_n` low at SOFT cycle 5 → `sync_reset` stays 1, `soft_ack` never pulses; after release the full 19-edge sequence repeats.
4. Glitch: a 2 ns `async_reset_n` low pulse in RUN → `sync_reset` = 1 immediately, `ready` = 0, full release sequence follows.
5. Request during HOLD: hold `soft_req` high through HOLD → no effect until the first RUN edge, then SOFT. Keep `soft_req` high past `soft_ack` → a second 16-cycle soft reset starts.
6. Integration: drive dff_syncres `sync_reset` from this block, with `d` toggling every 23 ns → `q` = 0 at every edge where `sync_reset` = 1; otherwise `q` follows `d` one edge later.
